// File: rtl/clkdiv_pkg.sv
// Shared constants for the programmable clock divider: counter width default,
// divisor floor, divisor clamp helper and per-level game speed divisors.
package clkdiv_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int DIV_MIN   = 2;

  typedef enum logic [2:0] {
    LVL_0, LVL_1, LVL_2, LVL_3, LVL_4, LVL_5, LVL_6, LVL_7
  } speed_lvl_e;

  // Fall-rate divisors: higher levels fall faster (smaller divisor).
  function automatic logic [31:0] level_div(input speed_lvl_e lvl);
    case (lvl)
      LVL_0:   return 32'd48000;
      LVL_1:   return 32'd40000;
      LVL_2:   return 32'd32000;
      LVL_3:   return 32'd25000;
      LVL_4:   return 32'd19000;
      LVL_5:   return 32'd14000;
      LVL_6:   return 32'd10000;
      default: return 32'd7000;
    endcase
  endfunction

  function automatic logic [31:0] clamp_div(input logic [31:0] v);
    return (v < 32'(DIV_MIN)) ? 32'(DIV_MIN) : v;
  endfunction

endpackage

// File: rtl/prog_clock_divider.sv
// Runtime-programmable integer clock divider producing a registered square
// wave and a one-cycle tick per output period, with shadowed divisor updates.
module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] div_cur,
  output logic             pending
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] pend_val_q, pend_val_d;
  logic             pending_q, pending_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] ld_val;
  logic             wrap;

  assign ld_val = CNT_W'(clamp_div(32'(div_in)));
  assign wrap   = en && (cnt_q == div_cur_q - CNT_W'(1));

  always_comb begin
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    pend_val_d = pend_val_q;
    pending_d  = pending_q;
    clk_out_d  = clk_out_q;
    tick_d     = 1'b0;

    if (sync) begin
      // Phase restart applies any new divisor at once; the new period starts at cnt=0.
      cnt_d     = '0;
      clk_out_d = 1'b0;
      pending_d = 1'b0;
      if (div_load) begin
        div_cur_d = ld_val;
      end else if (pending_q) begin
        div_cur_d = pend_val_q;
      end
    end else begin
      if (wrap) begin
        // Divisor only changes at the period boundary so no period mixes two N.
        pending_d = 1'b0;
        if (div_load) begin
          div_cur_d = ld_val;
        end else if (pending_q) begin
          div_cur_d = pend_val_q;
        end
      end else if (div_load) begin
        pend_val_d = ld_val;
        pending_d  = 1'b1;
      end

      if (en) begin
        if (wrap) begin
          cnt_d     = '0;
          clk_out_d = 1'b0;
          tick_d    = 1'b1;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          clk_out_d = (cnt_q + CNT_W'(1)) >= (div_cur_q >> 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      div_cur_q  <= CNT_W'(DIV_RST);
      pend_val_q <= '0;
      pending_q  <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      pend_val_q <= pend_val_d;
      pending_q  <= pending_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign div_cur = div_cur_q;
  assign pending = pending_q;

endmodule
